// File: rtl/costas_loop_filter_pi.sv
// Proportional-integral Costas carrier loop filter with saturating arithmetic.
// Pull-in and tracking gains are switched by a lock detector that runs on accepted samples.
module costas_loop_filter_pi #(
  parameter int IN_W       = 34,
  parameter int OUT_W      = 17,
  parameter int ACC_W      = 32,
  parameter int KP_PULL    = 4,
  parameter int KI_PULL    = 8,
  parameter int KP_TRACK   = 6,
  parameter int KI_TRACK   = 12,
  parameter int LOCK_THR   = 1024,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_THR = 4096,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [IN_W-1:0]  phase_error,
  input  logic                    err_valid,
  input  logic                    freeze,
  input  logic                    int_load,
  input  logic signed [ACC_W-1:0] int_load_val,
  output logic signed [OUT_W-1:0] correction,
  output logic                    corr_valid,
  output logic                    locked,
  output logic signed [ACC_W-1:0] integ
);

  localparam int SW   = ((IN_W > ACC_W) ? IN_W : ACC_W) + 2;
  localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, PULL, TRACK} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [IN_W-1:0]  p_reg;
  logic                    s1_valid;

  logic                    accept;
  logic signed [IN_W-1:0]  p_shift;
  logic signed [IN_W-1:0]  i_shift;
  logic [IN_W-1:0]         err_abs;
  logic                    in_lock;
  logic                    out_lock;
  logic signed [SW-1:0]    int_sum;
  logic signed [SW-1:0]    out_sum;
  logic signed [ACC_W-1:0] int_sat;
  logic signed [OUT_W-1:0] out_sat;

  assign accept = err_valid && (state != IDLE);

  always_comb begin
    p_shift = phase_error >>> KP_PULL;
    i_shift = phase_error >>> KI_PULL;
    if (state == TRACK) begin
      p_shift = phase_error >>> KP_TRACK;
      i_shift = phase_error >>> KI_TRACK;
    end
  end

  // The most-negative input has no positive twin, so it maps to the largest magnitude.
  always_comb begin
    err_abs = phase_error;
    if (phase_error[IN_W-1]) begin
      if (phase_error == {1'b1, {(IN_W-1){1'b0}}})
        err_abs = {1'b0, {(IN_W-1){1'b1}}};
      else
        err_abs = $unsigned(-phase_error);
    end
  end

  assign in_lock  = err_abs <  IN_W'(LOCK_THR);
  assign out_lock = err_abs >= IN_W'(UNLOCK_THR);

  assign int_sum = {{(SW-ACC_W){integ[ACC_W-1]}}, integ}
                 + {{(SW-IN_W){i_shift[IN_W-1]}}, i_shift};
  assign out_sum = {{(SW-IN_W){p_reg[IN_W-1]}}, p_reg}
                 + {{(SW-ACC_W){integ[ACC_W-1]}}, integ};

  // Sums carry two guard bits, so a sign-extension mismatch means overflow of the target width.
  always_comb begin
    if (int_sum[SW-1:ACC_W-1] == {(SW-ACC_W+1){int_sum[SW-1]}})
      int_sat = int_sum[ACC_W-1:0];
    else if (int_sum[SW-1])
      int_sat = {1'b1, {(ACC_W-1){1'b0}}};
    else
      int_sat = {1'b0, {(ACC_W-1){1'b1}}};

    if (out_sum[SW-1:OUT_W-1] == {(SW-OUT_W+1){out_sum[SW-1]}})
      out_sat = out_sum[OUT_W-1:0];
    else if (out_sum[SW-1])
      out_sat = {1'b1, {(OUT_W-1){1'b0}}};
    else
      out_sat = {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      p_reg      <= '0;
      s1_valid   <= 1'b0;
      correction <= '0;
      corr_valid <= 1'b0;
      locked     <= 1'b0;
      integ      <= '0;
    end else begin
      s1_valid   <= accept;
      corr_valid <= s1_valid;
      if (accept)
        p_reg <= p_shift;
      if (s1_valid)
        correction <= out_sat;

      if (state != IDLE) begin
        if (int_load)
          integ <= int_load_val;
        else if (accept && !freeze)
          integ <= int_sat;
      end

      // Lock detector: consecutive qualifying samples move between pull-in and tracking.
      if (!enable) begin
        state  <= IDLE;
        cnt    <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= PULL;
            cnt   <= '0;
          end
          PULL: if (accept) begin
            if (!in_lock)
              cnt <= '0;
            else if (cnt == CW'(LOCK_CNT - 1)) begin
              state  <= TRACK;
              cnt    <= '0;
              locked <= 1'b1;
            end else
              cnt <= cnt + CW'(1);
          end
          TRACK: if (accept) begin
            if (!out_lock)
              cnt <= '0;
            else if (cnt == CW'(UNLOCK_CNT - 1)) begin
              state  <= PULL;
              cnt    <= '0;
              locked <= 1'b0;
            end else
              cnt <= cnt + CW'(1);
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_costas_loop_filter_pi.sv
// Self-checking bench for costas_loop_filter_pi: directed scenarios plus randomized
// back-to-back traffic compared against an arithmetic reference model.
module tb_costas_loop_filter_pi;

  localparam int IN_W  = 34;
  localparam int OUT_W = 17;
  localparam int ACC_W = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    enable = 1'b0;
  logic signed [IN_W-1:0]  phase_error = '0;
  logic                    err_valid = 1'b0;
  logic                    freeze = 1'b0;
  logic                    int_load = 1'b0;
  logic signed [ACC_W-1:0] int_load_val = '0;
  logic signed [OUT_W-1:0] correction;
  logic                    corr_valid;
  logic                    locked;
  logic signed [ACC_W-1:0] integ;

  int checks = 0;
  int errors = 0;

  costas_loop_filter_pi dut (
    .clk(clk), .rst(rst), .enable(enable), .phase_error(phase_error),
    .err_valid(err_valid), .freeze(freeze), .int_load(int_load),
    .int_load_val(int_load_val), .correction(correction), .corr_valid(corr_valid),
    .locked(locked), .integ(integ)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle, 1=pull-in, 2=tracking; results queued with due cycle.
  int     cyc = 0;
  int     m_state = 0;
  int     m_cnt = 0;
  longint m_integ = 0;
  longint m_corr = 0;
  bit     exp_cv = 1'b0;
  int     q_due[$];
  longint q_val[$];

  function automatic longint sat(input longint v, input int w);
    longint mx;
    longint mn;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic longint mag(input longint pe);
    if (pe == -(64'sd1 <<< (IN_W - 1))) return (64'sd1 <<< (IN_W - 1)) - 1;
    return (pe < 0) ? -pe : pe;
  endfunction

  function automatic void model_step(input bit en, input longint pe, input bit ev,
                                     input bit frz, input bit ld, input longint ldval);
    bit     acc;
    longint inew;
    longint pn;
    acc  = ev && (m_state != 0);
    inew = m_integ;
    if (acc) begin
      pn = pe >>> ((m_state == 2) ? 6 : 4);
      if (ld)        inew = ldval;
      else if (!frz) inew = sat(m_integ + (pe >>> ((m_state == 2) ? 12 : 8)), ACC_W);
      q_due.push_back(cyc + 2);
      q_val.push_back(sat(pn + inew, OUT_W));
    end
    if (m_state != 0) begin
      if (ld)       m_integ = ldval;
      else if (acc) m_integ = inew;
    end
    if (!en) begin
      m_state = 0; m_cnt = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_cnt = 0;
    end else if (acc && m_state == 1) begin
      if (mag(pe) < 1024) begin
        m_cnt++;
        if (m_cnt == 16) begin m_state = 2; m_cnt = 0; end
      end else m_cnt = 0;
    end else if (acc && m_state == 2) begin
      if (mag(pe) >= 4096) begin
        m_cnt++;
        if (m_cnt == 4) begin m_state = 1; m_cnt = 0; end
      end else m_cnt = 0;
    end
  endfunction

  task automatic drive(input bit en, input longint pe, input bit ev,
                       input bit frz, input bit ld, input longint ldval);
    enable       = en;
    phase_error  = pe[IN_W-1:0];
    err_valid    = ev;
    freeze       = frz;
    int_load     = ld;
    int_load_val = ldval[ACC_W-1:0];
    model_step(en, pe, ev, frz, ld, ldval);
    @(posedge clk); #1;
    cyc++;
    err_valid = 1'b0;
    freeze    = 1'b0;
    int_load  = 1'b0;
    exp_cv    = 1'b0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      exp_cv = 1'b1;
      m_corr = q_val.pop_front();
      void'(q_due.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; err_valid = 1'b0; freeze = 1'b0; int_load = 1'b0;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    m_state = 0; m_cnt = 0; m_integ = 0; m_corr = 0; exp_cv = 1'b0;
    q_due.delete(); q_val.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (correction !== '0) begin errors++; $display("[TB] FAIL reset_corr: got %0d expected 0", correction); end
    if (corr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cv: got %0b expected 0", corr_valid); end
    if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0b expected 0", locked); end
    if (integ !== '0) begin errors++; $display("[TB] FAIL reset_integ: got %0d expected 0", integ); end
  endtask

  task automatic test_pull_seq();
    longint ec[3] = '{272, 288, 304};
    longint ei[3] = '{16, 32, 48};
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 4096, 1, 0, 0, 0);
      checks++;
      if (longint'(integ) != ei[k]) begin errors++; $display("[TB] FAIL pull_integ[%0d]: got %0d expected %0d", k, integ, ei[k]); end
      drive(1, 0, 0, 0, 0, 0);
      checks += 2;
      if (corr_valid !== 1'b1) begin errors++; $display("[TB] FAIL pull_cv[%0d]: got %0b expected 1", k, corr_valid); end
      if (longint'(correction) != ec[k]) begin errors++; $display("[TB] FAIL pull_corr[%0d]: got %0d expected %0d", k, correction, ec[k]); end
      for (int j = 0; j < 8; j++) begin
        drive(1, 0, 0, 0, 0, 0);
        checks++;
        if (corr_valid !== exp_cv) begin errors++; $display("[TB] FAIL pull_cv_idle: got %0b expected %0b", corr_valid, exp_cv); end
      end
    end
  endtask

  task automatic test_floor();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, -1, 1, 0, 0, 0);
    checks++;
    if (longint'(integ) != -1) begin errors++; $display("[TB] FAIL floor_integ: got %0d expected -1", integ); end
    drive(1, 0, 0, 0, 0, 0);
    checks += 2;
    if (corr_valid !== 1'b1) begin errors++; $display("[TB] FAIL floor_cv: got %0b expected 1", corr_valid); end
    if (longint'(correction) != -2) begin errors++; $display("[TB] FAIL floor_corr: got %0d expected -2", correction); end
  endtask

  task automatic test_saturation();
    for (int s = 0; s < 2; s++) begin
      longint sg = (s == 0) ? 1 : -1;
      do_reset();
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 1, sg * (64'sd2147483648 - 16));
      for (int k = 0; k < 3; k++) drive(1, sg * (64'sd1 <<< 20), 1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      checks += 4;
      if (longint'(integ) != ((s == 0) ? 64'sd2147483647 : -64'sd2147483648))
        begin errors++; $display("[TB] FAIL sat_integ[%0d]: got %0d", s, integ); end
      if (longint'(correction) != ((s == 0) ? 65535 : -65536))
        begin errors++; $display("[TB] FAIL sat_corr[%0d]: got %0d", s, correction); end
      if (longint'(integ) != m_integ) begin errors++; $display("[TB] FAIL sat_integ_model: got %0d expected %0d", integ, m_integ); end
      if (longint'(correction) != m_corr) begin errors++; $display("[TB] FAIL sat_corr_model: got %0d expected %0d", correction, m_corr); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      drive(1, (k == 15) ? 2000 : 100, 1, 0, 0, 0);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_broken[%0d]: got %0b expected 0", k, locked); end
    end
    for (int k = 0; k < 16; k++) begin
      drive(1, 100, 1, 0, 0, 0);
      checks += 2;
      if (locked !== (k == 15)) begin errors++; $display("[TB] FAIL lock_rise[%0d]: got %0b expected %0b", k, locked, k == 15); end
      if (longint'(correction) != m_corr) begin errors++; $display("[TB] FAIL lock_corr: got %0d expected %0d", correction, m_corr); end
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, -5000, 1, 0, 0, 0);
      checks += 2;
      if (locked !== (k < 3)) begin errors++; $display("[TB] FAIL lock_fall[%0d]: got %0b expected %0b", k, locked, k < 3); end
      if (longint'(correction) != m_corr) begin errors++; $display("[TB] FAIL track_corr: got %0d expected %0d", correction, m_corr); end
    end
  endtask

  task automatic test_freeze_load();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 4096, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    checks += 2;
    if (longint'(integ) != 0) begin errors++; $display("[TB] FAIL freeze_integ: got %0d expected 0", integ); end
    if (longint'(correction) != 256) begin errors++; $display("[TB] FAIL freeze_corr: got %0d expected 256", correction); end
    drive(1, 4096, 1, 0, 1, 1000);
    checks++;
    if (longint'(integ) != 1000) begin errors++; $display("[TB] FAIL load_integ: got %0d expected 1000", integ); end
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (longint'(correction) != 1256) begin errors++; $display("[TB] FAIL load_corr: got %0d expected 1256", correction); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 4096, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 4096, 1, k[0], 1, 777);
      checks += 4;
      if (corr_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_cv: got %0b expected 0", corr_valid); end
      if (longint'(correction) != 272) begin errors++; $display("[TB] FAIL idle_corr: got %0d expected 272", correction); end
      if (locked !== 1'b0) begin errors++; $display("[TB] FAIL idle_locked: got %0b expected 0", locked); end
      if (longint'(integ) != 16) begin errors++; $display("[TB] FAIL idle_integ: got %0d expected 16", integ); end
    end
  endtask

  task automatic test_reset_flight();
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 4096, 1, 0, 0, 0);
    do_reset();
    checks += 3;
    if (corr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flight_cv: got %0b expected 0", corr_valid); end
    if (correction !== '0) begin errors++; $display("[TB] FAIL flight_corr: got %0d expected 0", correction); end
    if (integ !== '0) begin errors++; $display("[TB] FAIL flight_integ: got %0d expected 0", integ); end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (corr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flight_cv2: got %0b expected 0", corr_valid); end
  endtask

  task automatic test_back_to_back();
    longint pe;
    longint r;
    do_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      int sel = $urandom_range(0, 99);
      r = {$urandom, $urandom};
      if (sel < 85)      pe = longint'($urandom_range(0, 2046)) - 1023;
      else if (sel < 95) pe = longint'($urandom_range(0, 20000)) - 10000;
      else               pe = r >>> (64 - IN_W);
      if (i == 300) pe = -(64'sd1 <<< (IN_W - 1));
      r = {$urandom, $urandom};
      drive(1, pe, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 31) == 0), r >>> 32);
      checks += 4;
      if (corr_valid !== exp_cv) begin errors++; $display("[TB] FAIL rnd_cv[%0d]: got %0b expected %0b", i, corr_valid, exp_cv); end
      if (longint'(correction) != m_corr) begin errors++; $display("[TB] FAIL rnd_corr[%0d]: got %0d expected %0d", i, correction, m_corr); end
      if (longint'(integ) != m_integ) begin errors++; $display("[TB] FAIL rnd_integ[%0d]: got %0d expected %0d", i, integ, m_integ); end
      if (locked !== (m_state == 2)) begin errors++; $display("[TB] FAIL rnd_locked[%0d]: got %0b expected %0b", i, locked, m_state == 2); end
    end
  endtask

  initial begin
    test_reset();
    test_pull_seq();
    test_floor();
    test_saturation();
    test_lock();
    test_freeze_load();
    test_enable_drop();
    test_reset_flight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/costas_loop_filter_pi.md
Name: costas_loop_filter_pi

Overview:
- Parametrised second-order (proportional-integral) Costas carrier loop filter with saturating arithmetic and gain scheduling.
- Sits between the Costas phase discriminator and the carrier NCO. Consumes one phase-error sample per integrate-and-dump period and produces a signed frequency correction word for the NCO.
- Wide gains are used during pull-in. A lock detector switches to narrow tracking gains, and back again on loss of lock.

Parameters:
- IN_W, 34: phase_error width (signed)
- OUT_W, 17: correction width (signed)
- ACC_W, 32: integrator width (signed)
- KP_PULL, 4: proportional right-shift, pull-in
- KI_PULL, 8: integral right-shift, pull-in
- KP_TRACK, 6: proportional right-shift, tracking
- KI_TRACK, 12: integral right-shift, tracking
- LOCK_THR, 1024: |err| strictly below this counts toward lock
- LOCK_CNT, 16: consecutive in-threshold samples needed to declare lock
- UNLOCK_THR, 4096: |err| at or above this counts toward unlock
- UNLOCK_CNT, 4: consecutive out-of-threshold samples needed to declare loss of lock

Ports:
- clk, in, 1: clock
- rst, in, 1: synchronous active-high reset
- enable, in, 1: loop enable
- phase_error, in, IN_W: signed discriminator output
- err_valid, in, 1: one-cycle strobe qualifying phase_error
- freeze, in, 1: hold integrator; proportional path stays active
- int_load, in, 1: one-cycle strobe to preload the integrator
- int_load_val, in, ACC_W: signed preload value
- correction, out, OUT_W: signed NCO correction, registered
- corr_valid, out, 1: one-cycle strobe, correction updated this cycle
- locked, out, 1: high while state is TRACK
- integ, out, ACC_W: integrator value, for debug/telemetry

Behaviour:
- Reset: done synchronously on the clk edge while rst=1. Sets correction=0, corr_valid=0, locked=0, integ=0, state=IDLE, lock counter=0. Reset has priority over everything; a sample in flight is discarded.
- States: IDLE, PULL, TRACK.
  - IDLE->PULL on the first cycle with enable=1.
  - Any state->IDLE on enable=0. Entering IDLE clears the counter and holds integ and correction. While in IDLE, err_valid, int_load and freeze are ignored.
- Gain select: the shifts applied to a sample are those of the state in the cycle err_valid is sampled. PULL uses KP_PULL/KI_PULL; TRACK uses KP_TRACK/KI_TRACK.
- Sample accepted at cycle N when err_valid=1 and state!=IDLE.
- Cycle N+1 registers:
  - p = phase_error >>> KP (arithmetic shift, floor toward -inf; e.g. -1>>>4 = -1).
  - integ_new = sat_ACC(integ + (phase_error >>> KI)), unless freeze=1 (integ held).
- Cycle N+2: correction = sat_OUT(p + integ_new), and corr_valid=1 for exactly one cycle.
- Latency is 2 cycles from err_valid to corr_valid.
- Accepted samples may arrive on consecutive cycles; the pipeline is fully pipelined with throughput 1/cycle.
- Intermediate sums are computed at max(IN_W,ACC_W)+2 bits before saturation, so no wrap is possible.
- Saturation limits:
  - sat_ACC clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - sat_OUT clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- int_load (state!=IDLE):
  - integ <= int_load_val at the next edge.
  - If it coincides with an accepted sample, load wins over the integral increment, and that sample's output = sat_OUT(p + int_load_val).
  - int_load has priority over freeze.
- Lock detection runs on accepted samples only:
  - abs = |phase_error|; the most-negative input maps to 2^(IN_W-1)-1.
  - PULL: abs<LOCK_THR increments the counter, otherwise the counter clears. When the counter reaches LOCK_CNT, state->TRACK and the counter clears.
  - TRACK: abs>=UNLOCK_THR increments the counter, otherwise the counter clears. When the counter reaches UNLOCK_CNT, state->PULL and the counter clears.
  - The state change takes effect at N+1; the next accepted sample uses the new gains.
- Outputs:
  - locked is registered: locked = (state==TRACK).
  - integ continuously reflects the integrator register.
- Holding: correction holds its value between strobes and across freeze and IDLE.

Test Plan:
- Reset, enable=1, phase_error=4096 strobed every 10 cycles (PULL) -> corr_valid 2 cycles after each strobe; correction sequence 272, 288, 304; integ 16, 32, 48.
- phase_error=-1 single strobe in PULL from reset -> integ=-1, correction=-2 (floor shift check).
- int_load with int_load_val=2^31-16, then phase_error=2^20 strobes -> integ clamps to 2147483647; correction clamps to 65535. Negative mirror -> integ=-2147483648, correction=-65536.
- 16 consecutive strobes with phase_error=100 -> locked rises 1 cycle after the 16th strobe. A 15-run broken by phase_error=2000 -> stays unlocked. Then 4 strobes of phase_error=-5000 in TRACK -> locked falls 1 cycle after the 4th.
- freeze=1 with phase_error=4096 in PULL from integ=0 -> integ stays 0, correction=256. Simultaneous int_load (val=1000) and err_valid (4096) -> integ=1000, correction=1256.
- enable dropped mid-run: strobes ignored, corr_valid stays 0, correction held, locked=0. rst asserted one cycle after a strobe -> no corr_valid, all outputs 0 next cycle.
